kernel_jacobi_2d_addr_divmod: RTL

Sequential unsigned divide/modulo unit that splits a flat array index back into row and column for the jacobi-2d kernel. It computes quotient = dividend / divisor and remainder = dividend % divisor. It is the inverse of the row-times-stride multiplier used when the kernel forms linear addresses. It sits between the flat-index address stream and the row/column boundary-test logic. Input and output use valid/ready handshakes, and the unit processes one operation at a time.

---
 rtl/kernel_jacobi_2d_addr_divmod.sv | 133 +++++++++++++
 1 files changed

// File: rtl/kernel_jacobi_2d_addr_divmod.sv
// Purpose : sequential unsigned divide/modulo that splits a flat jacobi-2d index into row (quotient) and column (remainder).
// Latency : DIVIDEND_WIDTH cycles from acceptance to out_valid (1 cycle for divide-by-zero); one operation in flight.
// Backpr. : in_ready only in IDLE; the result is held on quotient/remainder/err with out_valid until out_ready.
//
// Ports:
//    ap_clk, ap_rst_n        clock, synchronous active-low reset
//    in_valid/in_ready       operation handshake carrying dividend and divisor
//    out_valid/out_ready     result handshake carrying quotient, remainder, err
//    err                     divide-by-zero or quotient wider than QUOT_WIDTH (quotient saturated)
module kernel_jacobi_2d_addr_divmod #(
   parameter int DIVIDEND_WIDTH = 20,
   parameter int DIVISOR_WIDTH  = 11,
   parameter int QUOT_WIDTH     = 10
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOT_WIDTH-1:0]     quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      err
);

   localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   logic [DIVIDEND_WIDTH-1:0] dvd_sh;     // dividend, consumed MSB first by shifting left
   logic [DIVISOR_WIDTH-1:0]  dsr;
   logic [DIVISOR_WIDTH:0]    prem;       // partial remainder
   logic [DIVIDEND_WIDTH-1:0] quo_full;   // untruncated quotient
   logic [CNT_W-1:0]          cnt;
   logic                      dz;         // registered divisor was zero

   logic [DIVISOR_WIDTH:0]    prem_sh;
   logic [DIVISOR_WIDTH:0]    prem_nxt;
   logic                      ge;
   logic [DIVIDEND_WIDTH-1:0] quo_nxt;
   logic                      ovf;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor when it fits. The partial remainder is
   // always below the divisor, so its top bit is zero before the shift and
   // nothing is lost by shifting.
   always_comb begin
      prem_sh  = (prem << 1) | {{DIVISOR_WIDTH{1'b0}}, dvd_sh[DIVIDEND_WIDTH-1]};
      ge       = (prem_sh >= {1'b0, dsr});
      prem_nxt = ge ? (prem_sh - {1'b0, dsr}) : prem_sh;
      quo_nxt  = (quo_full << 1) | {{(DIVIDEND_WIDTH-1){1'b0}}, ge};
      ovf      = |quo_nxt[DIVIDEND_WIDTH-1:QUOT_WIDTH];
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         err       <= 1'b0;
         dvd_sh    <= '0;
         dsr       <= '0;
         prem      <= '0;
         quo_full  <= '0;
         cnt       <= '0;
         dz        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dvd_sh   <= dividend;
                  dsr      <= divisor;
                  dz       <= (divisor == '0);
                  prem     <= '0;
                  quo_full <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end

            CALC: begin
               if (dz) begin
                  // Divide-by-zero skips the iterations; it still spends one
                  // cycle here so its result appears one cycle after acceptance.
                  quotient  <= '1;
                  remainder <= '1;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  prem     <= prem_nxt;
                  quo_full <= quo_nxt;
                  dvd_sh   <= dvd_sh << 1;
                  cnt      <= cnt + 1'b1;
                  if (cnt == CNT_W'(DIVIDEND_WIDTH - 1)) begin
                     // Last bit: publish directly from the next-state values.
                     quotient  <= ovf ? '1 : quo_nxt[QUOT_WIDTH-1:0];
                     remainder <= prem_nxt[DIVISOR_WIDTH-1:0];
                     err       <= ovf;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
